// File: rtl/regfile_sb.sv
// 2R/2W register file with async clear, same-cycle write-to-read bypass and a
// per-register pending-write scoreboard for the decode stage.

module regfile_sb_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit_a,
  input  logic              hit_b,
  input  logic              set,
  input  logic [DATA_W-1:0] wd_a,
  input  logic [DATA_W-1:0] wd_b,
  output logic [DATA_W-1:0] q,
  output logic              busy
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (hit_b)      q <= wd_b;
      else if (hit_a) q <= wd_a;
      // a new producer supersedes the write-back of the old one
      if (set)                busy <= 1'b1;
      else if (hit_a | hit_b) busy <= 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd1_busy,
  output logic              rd2_busy,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0]             hit_a, hit_b, set, busy_q;
  logic [NREGS-1:0][DATA_W-1:0] rf_q;

  // Register 0 under ZERO_REG never sees a hit or set, so it stays at its
  // reset value of 0 and never becomes busy.
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    localparam bit TIE = (ZERO_REG != 0) && (r == 0);
    assign hit_a[r] = !TIE && we_a      && (wa_a     == ADDR_W'(r));
    assign hit_b[r] = !TIE && we_b      && (wa_b     == ADDR_W'(r));
    assign set[r]   = !TIE && iss_valid && (iss_addr == ADDR_W'(r));

    regfile_sb_cell #(.DATA_W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .hit_a (hit_a[r]),
      .hit_b (hit_b[r]),
      .set   (set[r]),
      .wd_a  (wd_a),
      .wd_b  (wd_b),
      .q     (rf_q[r]),
      .busy  (busy_q[r])
    );
  end

  logic [1:0][ADDR_W-1:0] ra;
  logic [1:0][DATA_W-1:0] rd;
  logic [1:0]             rd_busy;

  assign ra = {ra2, ra1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    if (BYPASS != 0) begin : g_byp
      // bypass is gated by reset so outputs read 0 while rst_n is held
      always_comb begin
        rd[p]      = rf_q[ra[p]];
        rd_busy[p] = busy_q[ra[p]];
        if (rst_n && (hit_a[ra[p]] || hit_b[ra[p]])) begin
          rd[p]      = hit_b[ra[p]] ? wd_b : wd_a;
          rd_busy[p] = 1'b0;
        end
      end
    end else begin : g_nobyp
      assign rd[p]      = rf_q[ra[p]];
      assign rd_busy[p] = busy_q[ra[p]];
    end
  end

  assign rd1      = rd[0];
  assign rd2      = rd[1];
  assign rd1_busy = rd_busy[0];
  assign rd2_busy = rd_busy[1];

  logic [ADDR_W:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) cnt_d += (ADDR_W+1)'(busy_q[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= '0;
    else        busy_cnt <= cnt_d;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: behavioural model compared every cycle on the default
// build, directed literal checks on it and on a BYPASS=0, ADDR_W=3 build.

module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, iss_addr, wa_a, wa_b;
  logic [31:0] rd1, rd2, wd_a, wd_b;
  logic        rd1_busy, rd2_busy, iss_valid, we_a, we_b;
  logic [5:0]  busy_cnt;

  logic [2:0]  s_ra1, s_ra2, s_iss_addr, s_wa_a, s_wa_b;
  logic [31:0] s_rd1, s_rd2, s_wd_a, s_wd_b;
  logic        s_rd1_busy, s_rd2_busy, s_iss_valid, s_we_a, s_we_b;
  logic [3:0]  s_busy_cnt;

  int n_chk = 0, n_fail = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .busy_cnt(busy_cnt));

  regfile_sb #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
    .rd1_busy(s_rd1_busy), .rd2_busy(s_rd2_busy), .iss_valid(s_iss_valid),
    .iss_addr(s_iss_addr), .we_a(s_we_a), .wa_a(s_wa_a), .wd_a(s_wd_a),
    .we_b(s_we_b), .wa_b(s_wa_b), .wd_b(s_wd_b), .busy_cnt(s_busy_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the default build: storage, busy set and a lagged busy count.
  logic [31:0] rf_m [32];
  bit          busy_m [32];
  int          cnt_m;

  always @(posedge clk or negedge rst_n) begin
    int n;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin rf_m[i] <= '0; busy_m[i] <= 1'b0; end
      cnt_m <= 0;
    end else begin
      n = 0;
      for (int i = 0; i < 32; i++) n += int'(busy_m[i]);
      cnt_m <= n;
      if (we_a && wa_a != 0) begin rf_m[wa_a] <= wd_a; busy_m[wa_a] <= 1'b0; end
      if (we_b && wa_b != 0) begin rf_m[wa_b] <= wd_b; busy_m[wa_b] <= 1'b0; end
      if (iss_valid && iss_addr != 0) busy_m[iss_addr] <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst_n || a == 0)      return '0;
    if (we_b && wa_b == a)     return wd_b;
    if (we_a && wa_a == a)     return wd_a;
    return rf_m[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a);
    if (!rst_n || a == 0)                         return '0;
    if ((we_b && wa_b == a) || (we_a && wa_a == a)) return '0;
    return {31'd0, busy_m[a]};
  endfunction

  always @(negedge clk) if (run) begin
    chk("rd1",      rd1,      exp_rd(ra1));
    chk("rd2",      rd2,      exp_rd(ra2));
    chk("rd1_busy", {31'd0, rd1_busy}, exp_busy(ra1));
    chk("rd2_busy", {31'd0, rd2_busy}, exp_busy(ra2));
    chk("busy_cnt", {26'd0, busy_cnt}, cnt_m);
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    we_a = 0; we_b = 0; iss_valid = 0;
  endtask

  initial begin
    rst_n = 0; ra1 = 0; ra2 = 0; iss_valid = 0; iss_addr = 0;
    we_a = 0; wa_a = 0; wd_a = 0; we_b = 0; wa_b = 0; wd_b = 0;
    s_ra1 = 0; s_ra2 = 0; s_iss_valid = 0; s_iss_addr = 0;
    s_we_a = 0; s_wa_a = 0; s_wd_a = 0; s_we_b = 0; s_wa_b = 0; s_wd_b = 0;
    run = 1'b1;
    step; step;
    rst_n = 1;
    step;
    chk("reset busy_cnt", {26'd0, busy_cnt}, 32'd0);

    // reset mid-cycle clears stored data immediately
    we_a = 1; wa_a = 5; wd_a = 32'hDEAD_BEEF; ra1 = 5;
    step; idle;
    #2 chk("r5 written", rd1, 32'hDEAD_BEEF);
    rst_n = 0;
    #1 chk("r5 under reset", rd1, 32'd0);
    chk("cnt under reset", {26'd0, busy_cnt}, 32'd0);
    step; #3 rst_n = 1;
    step;
    chk("r5 after reset", rd1, 32'd0);

    // register 0 ignores writes and issues
    we_a = 1; wa_a = 0; wd_a = 32'h1234; iss_valid = 1; iss_addr = 0; ra1 = 0;
    #2 chk("r0 bypass", rd1, 32'd0);
    chk("r0 busy", {31'd0, rd1_busy}, 32'd0);
    step; idle; step;
    #2 chk("r0 stored", rd1, 32'd0);
    chk("r0 cnt", {26'd0, busy_cnt}, 32'd0);

    // dual write to the same register: port B wins
    step;
    we_a = 1; wa_a = 7; wd_a = 32'h11; we_b = 1; wa_b = 7; wd_b = 32'h22; ra1 = 7;
    #2 chk("r7 bypass B", rd1, 32'h22);
    step; idle;
    #2 chk("r7 stored B", rd1, 32'h22);

    // scoreboard set, write-back clear, lagged count
    iss_valid = 1; iss_addr = 3; ra2 = 3;
    step; idle;
    #2 chk("r3 busy", {31'd0, rd2_busy}, 32'd1);
    chk("cnt lag", {26'd0, busy_cnt}, 32'd0);
    step;
    we_a = 1; wa_a = 3; wd_a = 32'h55;
    #2 chk("cnt one", {26'd0, busy_cnt}, 32'd1);
    chk("r3 wb bypass", rd2, 32'h55);
    chk("r3 wb busy", {31'd0, rd2_busy}, 32'd0);
    step; idle;
    #2 chk("r3 clear", {31'd0, rd2_busy}, 32'd0);
    chk("cnt still one", {26'd0, busy_cnt}, 32'd1);
    step;
    #2 chk("cnt zero", {26'd0, busy_cnt}, 32'd0);

    // set and clear on the same register: set wins
    iss_valid = 1; iss_addr = 9; step; idle; step;
    iss_valid = 1; iss_addr = 9; we_a = 1; wa_a = 9; wd_a = 32'h99; ra1 = 9;
    #2 chk("r9 bypass", rd1, 32'h99);
    chk("r9 busy forced", {31'd0, rd1_busy}, 32'd0);
    step; idle;
    #2 chk("r9 data", rd1, 32'h99);
    chk("r9 still busy", {31'd0, rd1_busy}, 32'd1);
    chk("r9 cnt", {26'd0, busy_cnt}, 32'd1);
    step;
    #2 chk("r9 cnt hold", {26'd0, busy_cnt}, 32'd1);

    // pseudo-random traffic over a small address range for collisions
    for (int i = 0; i < 200; i++) begin
      step;
      we_a = 1'($urandom); wa_a = 5'($urandom_range(0, 7)); wd_a = $urandom;
      we_b = 1'($urandom); wa_b = 5'($urandom_range(0, 7)); wd_b = $urandom;
      iss_valid = 1'($urandom); iss_addr = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7)); ra2 = 5'($urandom_range(0, 7));
    end
    step; idle;

    // BYPASS=0 build: reads see the stored value only
    s_we_a = 1; s_wa_a = 2; s_wd_a = 32'hAAAA;
    step;
    s_wd_a = 32'hBBBB; s_ra1 = 2;
    #2 chk("nb r2 old", s_rd1, 32'hAAAA);
    step; s_we_a = 0;
    #2 chk("nb r2 new", s_rd1, 32'hBBBB);
    s_iss_valid = 1; s_iss_addr = 4;
    step; s_iss_valid = 0;
    s_we_a = 1; s_wa_a = 4; s_wd_a = 32'h44; s_ra1 = 4;
    #2 chk("nb busy not forced", {31'd0, s_rd1_busy}, 32'd1);
    chk("nb r4 old", s_rd1, 32'd0);
    step; s_we_a = 0;
    #2 chk("nb r4 clear", {31'd0, s_rd1_busy}, 32'd0);
    chk("nb r4 new", s_rd1, 32'h44);
    for (int i = 0; i < 8; i++) begin
      s_iss_valid = 1; s_iss_addr = 3'(i); step;
    end
    s_iss_valid = 0; s_ra1 = 7; s_ra2 = 0;
    step;
    #2 chk("nb cnt 7", {28'd0, s_busy_cnt}, 32'd7);
    chk("nb r7 busy", {31'd0, s_rd1_busy}, 32'd1);
    chk("nb r0 busy", {31'd0, s_rd2_busy}, 32'd0);

    step;
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
